// File: rtl/snake_pkg.sv
// Shared direction codes and field widths for the snake heading/position logic.
package snake_pkg;

    localparam int COORD_W = 6;
    localparam int DIR_W   = 2;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DIR_W-1:0]   dir_t;

    localparam dir_t UP    = 2'd0;
    localparam dir_t DOWN  = 2'd1;
    localparam dir_t RIGHT = 2'd2;
    localparam dir_t LEFT  = 2'd3;

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Bundle between the direction controller, the board buttons and the next-head calculator.
interface snake_dir_ctrl_if;
    import snake_pkg::*;

    logic [3:0] i_Btn;
    logic       i_Run;
    coord_t     i_Next_x;
    coord_t     i_Next_y;
    dir_t       i_Next_Way;
    dir_t       o_Way;
    dir_t       o_Push;
    coord_t     o_Head_x;
    coord_t     o_Head_y;
    logic       o_Step;

    modport slave (
        input  i_Btn, i_Run, i_Next_x, i_Next_y, i_Next_Way,
        output o_Way, o_Push, o_Head_x, o_Head_y, o_Step
    );

    modport master (
        output i_Btn, i_Run, i_Next_x, i_Next_y, i_Next_Way,
        input  o_Way, o_Push, o_Head_x, o_Head_y, o_Step
    );

endinterface

// File: rtl/snake_dir_ctrl_debounce.sv
// Single-button synchroniser and debouncer; emits a one-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int DB_CNT = 1000000,
    parameter int DB_W   = 20
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Btn,
    output logic o_Level,
    output logic o_Press
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic            press;
    logic [DB_W-1:0] cnt;

    // Counter measures how long the synced input has disagreed with the debounced level
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            press  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= i_Btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= ~level;
                press <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_Level = level;
    assign o_Press = press;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Holds the snake's committed heading/head position, latches the latest debounced
// direction press and commits the calculator's result on every step tick.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int     DB_CNT    = 1000000,
    parameter int     DB_W      = 20,
    parameter int     STEP_CYC  = 5000000,
    parameter int     STEP_W    = 23,
    parameter coord_t START_X   = 6'd32,
    parameter coord_t START_Y   = 6'd32,
    parameter dir_t   START_WAY = 2'd2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    snake_dir_ctrl_if.slave        bus
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

    logic [3:0]        press;
    logic [3:0]        unused_level;
    logic              press_any;
    dir_t              press_code;
    logic              tick;
    logic [STEP_W-1:0] timer;
    logic              pending;
    dir_t              push_q;
    dir_t              way_q;
    coord_t            head_x;
    coord_t            head_y;
    logic              step_q;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DB_CNT (DB_CNT),
            .DB_W   (DB_W)
        ) u_db (
            .i_Clk   (i_Clk),
            .i_Rst   (i_Rst),
            .i_Btn   (bus.i_Btn[g]),
            .o_Level (unused_level[g]),
            .o_Press (press[g])
        );
    end

    // Scan from the highest code down so the lowest simultaneous press wins
    always_comb begin
        press_any  = 1'b0;
        press_code = UP;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                press_any  = 1'b1;
                press_code = dir_t'(i);
            end
        end
    end

    assign tick = (timer == STEP_LAST) && bus.i_Run;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            timer   <= '0;
            pending <= 1'b0;
            push_q  <= START_WAY;
            way_q   <= START_WAY;
            head_x  <= START_X;
            head_y  <= START_Y;
            step_q  <= 1'b0;
        end else begin
            step_q <= tick;
            if (!bus.i_Run || tick) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (tick) begin
                head_x <= bus.i_Next_x;
                head_y <= bus.i_Next_y;
                way_q  <= bus.i_Next_Way;
            end
            // A press landing on the tick edge survives as the next pending command
            if (press_any) begin
                push_q  <= press_code;
                pending <= 1'b1;
            end else if (tick) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.o_Way    = way_q;
    assign bus.o_Push   = pending ? push_q : way_q;
    assign bus.o_Head_x = head_x;
    assign bus.o_Head_y = head_y;
    assign bus.o_Step   = step_q;

endmodule
